// File: rtl/gelato_warp_scheduler_if.sv
// Fetch-side bundle of the Gelato warp scheduler: warp launch/exit/redirect
// controls, instruction-buffer credit returns and the fetch request handshake.
interface gelato_warp_scheduler_if #(
  parameter int NUM_WARPS = 8,
  parameter int PC_W      = 32,
  parameter int WARP_ID_W = $clog2(NUM_WARPS)
);

  logic                 launch_valid;
  logic [WARP_ID_W-1:0] launch_id;
  logic [PC_W-1:0]      launch_pc;

  logic                 exit_valid;
  logic [WARP_ID_W-1:0] exit_id;

  logic                 redirect_valid;
  logic [WARP_ID_W-1:0] redirect_id;
  logic [PC_W-1:0]      redirect_pc;

  logic                 pop_valid;
  logic [WARP_ID_W-1:0] pop_id;

  logic                 fetch_valid;
  logic                 fetch_ready;
  logic [WARP_ID_W-1:0] fetch_warp_id;
  logic [PC_W-1:0]      fetch_pc;

  logic [NUM_WARPS-1:0] active_mask;

  // Scheduler side: originates fetch requests, consumes warp controls.
  modport master (
    input  launch_valid, launch_id, launch_pc,
    input  exit_valid, exit_id,
    input  redirect_valid, redirect_id, redirect_pc,
    input  pop_valid, pop_id,
    input  fetch_ready,
    output fetch_valid, fetch_warp_id, fetch_pc,
    output active_mask
  );

  // Frontend side: drives warp controls, accepts fetch requests.
  modport slave (
    output launch_valid, launch_id, launch_pc,
    output exit_valid, exit_id,
    output redirect_valid, redirect_id, redirect_pc,
    output pop_valid, pop_id,
    output fetch_ready,
    input  fetch_valid, fetch_warp_id, fetch_pc,
    input  active_mask
  );

endinterface

// File: rtl/gelato_warp_scheduler.sv
// Round-robin warp scheduler: tracks per-warp PC, active state and
// instruction-buffer credits, and issues one eligible warp's PC per cycle
// into a registered valid/ready fetch request.
module gelato_warp_scheduler #(
  parameter int NUM_WARPS  = 8,
  parameter int WARP_ID_W  = $clog2(NUM_WARPS),
  parameter int PC_W       = 32,
  parameter int IBUF_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  gelato_warp_scheduler_if.master  bus
);

  localparam int                CRED_W   = $clog2(IBUF_DEPTH + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(IBUF_DEPTH);

  typedef enum logic {
    WARP_IDLE   = 1'b0,
    WARP_ACTIVE = 1'b1
  } warp_state_e;

  warp_state_e          state_q [NUM_WARPS];
  warp_state_e          state_d [NUM_WARPS];
  logic [PC_W-1:0]      pc_q    [NUM_WARPS];
  logic [PC_W-1:0]      pc_d    [NUM_WARPS];
  logic [CRED_W-1:0]    cred_q  [NUM_WARPS];
  logic [CRED_W-1:0]    cred_d  [NUM_WARPS];

  logic [WARP_ID_W-1:0] rr_q;
  logic                 fetch_valid_q;
  logic [WARP_ID_W-1:0] fetch_id_q;
  logic [PC_W-1:0]      fetch_pc_q;

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] launch_hit;
  logic [NUM_WARPS-1:0] exit_hit;
  logic [NUM_WARPS-1:0] redirect_hit;
  logic [NUM_WARPS-1:0] pop_hit;
  logic [NUM_WARPS-1:0] issue_hit;
  logic [WARP_ID_W-1:0] winner;
  logic [WARP_ID_W-1:0] scan_id;
  logic                 any_eligible;
  logic                 can_load;
  logic                 issue;

  // Eligibility: active, holding a credit, and not already sitting in the
  // output register as a live request.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // logic, so no path leaves it unassigned and no latch is inferred.
    eligible = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      eligible[w] = (state_q[w] == WARP_ACTIVE) && (cred_q[w] != '0) &&
                    !(fetch_valid_q && (fetch_id_q == WARP_ID_W'(w)));
    end
  end

  // Round-robin pick: first eligible warp scanning upward from rr, modulo
  // NUM_WARPS (power of two, so the id adder wraps on its own).
  always_comb begin
    winner       = rr_q;
    any_eligible = 1'b0;
    scan_id      = rr_q;
    for (int i = 0; i < NUM_WARPS; i++) begin
      scan_id = rr_q + WARP_ID_W'(i);
      if (!any_eligible && eligible[scan_id]) begin
        winner       = scan_id;
        any_eligible = 1'b1;
      end
    end
  end

  assign can_load = !fetch_valid_q || bus.fetch_ready;
  assign issue    = can_load && any_eligible;

  // Decode the per-warp control pulses and the issue target.
  always_comb begin
    launch_hit   = '0;
    exit_hit     = '0;
    redirect_hit = '0;
    pop_hit      = '0;
    issue_hit    = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      launch_hit[w]   = bus.launch_valid   && (bus.launch_id   == WARP_ID_W'(w));
      exit_hit[w]     = bus.exit_valid     && (bus.exit_id     == WARP_ID_W'(w));
      redirect_hit[w] = bus.redirect_valid && (bus.redirect_id == WARP_ID_W'(w));
      pop_hit[w]      = bus.pop_valid      && (bus.pop_id      == WARP_ID_W'(w));
      issue_hit[w]    = issue && (winner == WARP_ID_W'(w));
    end
  end

  // Per-warp next state: IDLE/ACTIVE transitions, PC update and credits.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      state_d[w] = state_q[w];
      pc_d[w]    = pc_q[w];
      cred_d[w]  = cred_q[w];

      case (state_q[w])
        WARP_IDLE: begin
          // Exit beats a simultaneous launch: the warp stays idle.
          if (launch_hit[w] && !exit_hit[w]) begin
            state_d[w] = WARP_ACTIVE;
            pc_d[w]    = bus.launch_pc;
          end
        end
        WARP_ACTIVE: begin
          if (issue_hit[w]) pc_d[w] = pc_q[w] + PC_W'(4);
          // A redirect overrides the sequential advance of the same edge.
          if (redirect_hit[w]) pc_d[w] = bus.redirect_pc;
          if (exit_hit[w]) state_d[w] = WARP_IDLE;
        end
        default: state_d[w] = WARP_IDLE;
      endcase

      // Credits ignore active state; issue and pop together cancel out.
      if (issue_hit[w] && !pop_hit[w]) begin
        cred_d[w] = cred_q[w] - CRED_W'(1);
      end else if (pop_hit[w] && !issue_hit[w] && (cred_q[w] != CRED_MAX)) begin
        cred_d[w] = cred_q[w] + CRED_W'(1);
      end
    end
  end

  // Warp state register; rdy low freezes everything and drops that cycle's inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-warp PC/credit arrays are reset explicitly because their
      // reset values are architecturally visible (credits start full, pc at 0).
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= WARP_IDLE;
        pc_q[w]    <= '0;
        cred_q[w]  <= CRED_MAX;
      end
    end else if (rdy) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= state_d[w];
        pc_q[w]    <= pc_d[w];
        cred_q[w]  <= cred_d[w];
      end
    end
  end

  // Output register and round-robin pointer; a held request never changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q          <= '0;
      fetch_valid_q <= 1'b0;
      fetch_id_q    <= '0;
      fetch_pc_q    <= '0;
    end else if (rdy) begin
      if (issue) rr_q <= winner + WARP_ID_W'(1);
      if (can_load) begin
        if (any_eligible) begin
          fetch_valid_q <= 1'b1;
          fetch_id_q    <= winner;
          fetch_pc_q    <= pc_q[winner];
        end else begin
          fetch_valid_q <= 1'b0;
        end
      end
    end
  end

  // Active flags are a direct view of the registered warp states.
  always_comb begin
    bus.active_mask = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      bus.active_mask[w] = (state_q[w] == WARP_ACTIVE);
    end
  end

  assign bus.fetch_valid   = fetch_valid_q;
  assign bus.fetch_warp_id = fetch_id_q;
  assign bus.fetch_pc      = fetch_pc_q;

endmodule
